// File: rtl/dht_pkg.sv
// Shared definitions for the DHT11 acquisition controller: one-hot states,
// 40-bit frame field offsets and the DHT11 physical range limits.
package dht_pkg;

  typedef enum logic [4:0] {
    ST_IDLE       = 5'b00001,
    ST_REQUEST    = 5'b00010,
    ST_WAIT_FRAME = 5'b00100,
    ST_CHECK      = 5'b01000,
    ST_WAIT_GAP   = 5'b10000
  } state_t;

  // LSB offset of each byte in the sensor frame
  localparam int HUM_INT_LSB  = 32;
  localparam int HUM_DEC_LSB  = 24;
  localparam int TEMP_INT_LSB = 16;
  localparam int TEMP_DEC_LSB = 8;
  localparam int CSUM_LSB     = 0;

  localparam logic [7:0] HUM_MAX  = 8'd100;
  localparam logic [7:0] TEMP_MAX = 8'd60;

  function automatic logic [7:0] frame_byte(input logic [39:0] frame, input int lsb);
    return frame[lsb +: 8];
  endfunction

endpackage

// File: rtl/dht_frame_check.sv
// Combinational frame validation: checksum, plus the DHT11 range test when
// DHT_SAMPLER_RANGE_CHECK_EN is defined.
module dht_frame_check
  import dht_pkg::*;
(
  input  logic [39:0] frame,
  output logic        good
);

  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic [7:0] csum;
  logic [7:0] sum;
  logic       csum_ok;
  logic       range_ok;

  assign hum_int  = frame_byte(frame, HUM_INT_LSB);
  assign hum_dec  = frame_byte(frame, HUM_DEC_LSB);
  assign temp_int = frame_byte(frame, TEMP_INT_LSB);
  assign temp_dec = frame_byte(frame, TEMP_DEC_LSB);
  assign csum     = frame_byte(frame, CSUM_LSB);

  // 8-bit sum wraps, giving the modulo-256 checksum directly
  assign sum     = hum_int + hum_dec + temp_int + temp_dec;
  assign csum_ok = (sum == csum);

`ifdef DHT_SAMPLER_RANGE_CHECK_EN
  assign range_ok = (hum_int <= HUM_MAX) && (temp_int <= TEMP_MAX);
`else
  assign range_ok = 1'b1;
`endif

  assign good = csum_ok & range_ok;

endmodule

// File: rtl/dht_sampler.sv
// Periodic DHT11 acquisition controller with retry, fail flag and a
// valid/ready sample output. Optional range check: DHT_SAMPLER_RANGE_CHECK_EN.
module dht_sampler
  import dht_pkg::*;
#(
  parameter int PERIOD_CYCLES    = 200_000_000,
  parameter int TIMEOUT_CYCLES   = 10_000_000,
  parameter int RETRY_GAP_CYCLES = 100_000_000,
  parameter int MAX_RETRIES      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  output logic        start_o,
  input  logic [39:0] frame_i,
  input  logic        frame_valid_i,
  output logic        sample_valid_o,
  input  logic        sample_ready_i,
  output logic [7:0]  hum_int_o,
  output logic [7:0]  hum_dec_o,
  output logic [7:0]  temp_int_o,
  output logic [7:0]  temp_dec_o,
  output logic        fail_o,
  output logic        overrun_o,
  output logic [4:0]  state_dbg_o
);

  localparam int MAX_PT   = (PERIOD_CYCLES > TIMEOUT_CYCLES) ? PERIOD_CYCLES : TIMEOUT_CYCLES;
  localparam int MAX_CYC  = (MAX_PT > RETRY_GAP_CYCLES) ? MAX_PT : RETRY_GAP_CYCLES;
  localparam int TIMER_W  = $clog2(MAX_CYC + 1);
  localparam int RETRY_W  = $clog2(MAX_RETRIES + 1);

  // The gap timer counts down from gap-1 so WAIT_GAP lasts exactly gap cycles
  localparam logic [TIMER_W-1:0] PERIOD_LD    = TIMER_W'(PERIOD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] RETRY_LD     = TIMER_W'(RETRY_GAP_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [RETRY_W-1:0] retry_cnt;
  logic [RETRY_W-1:0] retry_next;
  logic [39:0]        frame_q;
  logic               good;
  logic               fail_now;
  logic               publish;

  dht_frame_check u_check (
    .frame (frame_q),
    .good  (good)
  );

  assign retry_next  = retry_cnt + 1'b1;
  assign fail_now    = ((state == ST_WAIT_FRAME) && !frame_valid_i && (timer == TIMEOUT_LAST)) ||
                       ((state == ST_CHECK) && !good);
  assign publish     = enable_i && (state == ST_CHECK) && good;
  assign state_dbg_o = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      timer     <= '0;
      retry_cnt <= '0;
      frame_q   <= '0;
      start_o   <= 1'b0;
      fail_o    <= 1'b0;
    end else begin
      start_o <= 1'b0;
      if (!enable_i) begin
        state     <= ST_IDLE;
        retry_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_REQUEST;
            start_o <= 1'b1;
          end
          ST_REQUEST: begin
            state <= ST_WAIT_FRAME;
            timer <= '0;
          end
          ST_WAIT_FRAME: begin
            if (frame_valid_i) begin
              frame_q <= frame_i;
              state   <= ST_CHECK;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_CHECK: begin
            if (good) begin
              retry_cnt <= '0;
              fail_o    <= 1'b0;
              timer     <= PERIOD_LD;
              state     <= ST_WAIT_GAP;
            end
          end
          ST_WAIT_GAP: begin
            if (timer == '0) begin
              state   <= ST_REQUEST;
              start_o <= 1'b1;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase

        // Timeout and bad frame share one failure path, overriding the case above
        if (fail_now) begin
          state <= ST_WAIT_GAP;
          if (retry_next == RETRY_LIMIT) begin
            fail_o    <= 1'b1;
            retry_cnt <= '0;
            timer     <= PERIOD_LD;
          end else begin
            retry_cnt <= retry_next;
            timer     <= RETRY_LD;
          end
        end
      end
    end
  end

  // valid/ready: sample_valid_o holds until a cycle with valid & ready; a
  // publish in that same cycle reloads data and keeps valid high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_valid_o <= 1'b0;
      hum_int_o      <= '0;
      hum_dec_o      <= '0;
      temp_int_o     <= '0;
      temp_dec_o     <= '0;
      overrun_o      <= 1'b0;
    end else if (publish) begin
      sample_valid_o <= 1'b1;
      hum_int_o      <= frame_byte(frame_q, HUM_INT_LSB);
      hum_dec_o      <= frame_byte(frame_q, HUM_DEC_LSB);
      temp_int_o     <= frame_byte(frame_q, TEMP_INT_LSB);
      temp_dec_o     <= frame_byte(frame_q, TEMP_DEC_LSB);
      if (sample_valid_o && !sample_ready_i) begin
        overrun_o <= 1'b1;
      end
    end else if (sample_valid_o && sample_ready_i) begin
      sample_valid_o <= 1'b0;
    end
  end

endmodule
